pic_command_sequencer: RTL and testbench

//  Clocked, parametrised successor to the combinational 8259A read/write decoder.

---
 rtl/pic_command_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_pic_command_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pic_command_sequencer.sv
// 8259A command sequencer: ICW1..ICW4 init FSM, OCW decode, register read-back.
// Optional poll command support is built when PIC_POLL_CMD_EN is defined.
module pic_command_sequencer #(
    parameter int                NUM_IR    = 8,
    parameter logic [NUM_IR-1:0] IMR_RESET = {NUM_IR{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chip_select_bar,
    input  logic              read_bar,
    input  logic              write_bar,
    input  logic              A0,
    input  logic [7:0]        data_bus_buffer_in,
    output logic [7:0]        data_bus_buffer_out,
    output logic              data_bus_oe,
    input  logic [NUM_IR-1:0] irr_in,
    input  logic [NUM_IR-1:0] isr_in,
    input  logic [7:0]        poll_word_in,
    output logic              ICW1_flag,
    output logic              ICW2_flag,
    output logic              ICW3_flag,
    output logic              ICW4_flag,
    output logic              OCW1_flag,
    output logic              OCW2_flag,
    output logic              OCW3_flag,
    output logic [7:0]        icw1_reg,
    output logic [7:0]        icw2_reg,
    output logic [7:0]        icw3_reg,
    output logic [7:0]        icw4_reg,
    output logic [NUM_IR-1:0] imr_out,
    output logic [7:0]        ocw2_reg,
    output logic [7:0]        ocw3_reg,
    output logic              init_done,
    output logic              poll_ack
);

    typedef enum logic [2:0] {
        S_ICW1, S_ICW2, S_ICW3, S_ICW4, S_READY
    } state_t;

    state_t     state, next_state;
    logic       wr_q, wr_armed, wr_a0;
    logic [7:0] wr_data;
    logic       commit, poll_sel;
    logic       ld_icw1, ld_icw2, ld_icw3, ld_icw4;
    logic       ld_ocw1, ld_ocw2, ld_ocw3;

    // Arm only on a sampled falling strobe so a strobe already low at reset is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q     <= 1'b0;
            wr_armed <= 1'b0;
            wr_a0    <= 1'b0;
            wr_data  <= 8'h00;
        end else begin
            wr_q <= write_bar;
            if (!chip_select_bar && !write_bar) begin
                wr_data <= data_bus_buffer_in;
                wr_a0   <= A0;
            end
            if (commit)
                wr_armed <= 1'b0;
            else if (!chip_select_bar && !write_bar && wr_q)
                wr_armed <= 1'b1;
            else if (chip_select_bar && !write_bar)
                wr_armed <= 1'b0;
        end
    end

    assign commit = wr_armed & ~wr_q & write_bar;

    always_ff @(posedge clk) begin
        if (reset) state <= S_ICW1;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        ld_icw1    = 1'b0;
        ld_icw2    = 1'b0;
        ld_icw3    = 1'b0;
        ld_icw4    = 1'b0;
        ld_ocw1    = 1'b0;
        ld_ocw2    = 1'b0;
        ld_ocw3    = 1'b0;
        if (commit) begin
            if (!wr_a0 && wr_data[4]) begin
                ld_icw1    = 1'b1;
                next_state = S_ICW2;
            end else begin
                unique case (state)
                    S_ICW2: if (wr_a0) begin
                        ld_icw2 = 1'b1;
                        if (!icw1_reg[1])     next_state = S_ICW3;
                        else if (icw1_reg[0]) next_state = S_ICW4;
                        else                  next_state = S_READY;
                    end
                    S_ICW3: if (wr_a0) begin
                        ld_icw3    = 1'b1;
                        next_state = icw1_reg[0] ? S_ICW4 : S_READY;
                    end
                    S_ICW4: if (wr_a0) begin
                        ld_icw4    = 1'b1;
                        next_state = S_READY;
                    end
                    S_READY: begin
                        if (wr_a0)           ld_ocw1 = 1'b1;
                        else if (wr_data[3]) ld_ocw3 = 1'b1;
                        else                 ld_ocw2 = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ICW1_flag <= 1'b0;
            ICW2_flag <= 1'b0;
            ICW3_flag <= 1'b0;
            ICW4_flag <= 1'b0;
            OCW1_flag <= 1'b0;
            OCW2_flag <= 1'b0;
            OCW3_flag <= 1'b0;
            icw1_reg  <= 8'h00;
            icw2_reg  <= 8'h00;
            icw3_reg  <= 8'h00;
            icw4_reg  <= 8'h00;
            imr_out   <= IMR_RESET;
            ocw2_reg  <= 8'h00;
            ocw3_reg  <= 8'h00;
        end else begin
            ICW1_flag <= ld_icw1;
            ICW2_flag <= ld_icw2;
            ICW3_flag <= ld_icw3;
            ICW4_flag <= ld_icw4;
            OCW1_flag <= ld_ocw1;
            OCW2_flag <= ld_ocw2;
            OCW3_flag <= ld_ocw3;
            if (ld_icw1) begin
                icw1_reg <= wr_data;
                icw2_reg <= 8'h00;
                icw3_reg <= 8'h00;
                icw4_reg <= 8'h00;
                imr_out  <= '0;
                ocw3_reg <= 8'h00;
            end
            if (ld_icw2) icw2_reg <= wr_data;
            if (ld_icw3) icw3_reg <= wr_data;
            if (ld_icw4) icw4_reg <= wr_data;
            if (ld_ocw1) imr_out  <= wr_data[NUM_IR-1:0];
            if (ld_ocw2) ocw2_reg <= wr_data;
            // RR gates the read select, ESMM gates the special-mask pair
            if (ld_ocw3) begin
                ocw3_reg[7]   <= wr_data[7];
                ocw3_reg[4:2] <= wr_data[4:2];
                if (wr_data[1]) ocw3_reg[1:0] <= wr_data[1:0];
                if (wr_data[6]) ocw3_reg[6:5] <= wr_data[6:5];
            end
        end
    end

    assign init_done   = (state == S_READY);
    assign data_bus_oe = ~chip_select_bar & ~read_bar & write_bar;

`ifdef PIC_POLL_CMD_EN
    logic poll_pending, rd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            poll_pending <= 1'b0;
            rd_q         <= 1'b0;
            poll_ack     <= 1'b0;
        end else begin
            rd_q     <= data_bus_oe;
            poll_ack <= 1'b0;
            if (ld_icw1)
                poll_pending <= 1'b0;
            else if (rd_q && !data_bus_oe && poll_pending) begin
                poll_ack     <= 1'b1;
                poll_pending <= 1'b0;
            end else if (ld_ocw3 && wr_data[2])
                poll_pending <= 1'b1;
        end
    end

    assign poll_sel = poll_pending;
`else
    logic unused_poll;
    assign unused_poll = ^poll_word_in;
    assign poll_sel    = 1'b0;
    assign poll_ack    = 1'b0;
`endif

    always_comb begin
        data_bus_buffer_out = 8'h00;
        if (data_bus_oe) begin
            if (poll_sel)
                data_bus_buffer_out = poll_word_in;
            else if (A0)
                data_bus_buffer_out = 8'(imr_out);
            else if (ocw3_reg[1:0] == 2'b11)
                data_bus_buffer_out = 8'(isr_in);
            else
                data_bus_buffer_out = 8'(irr_in);
        end
    end

endmodule

// File: tb/tb_pic_command_sequencer.sv
// Directed self-checking bench for pic_command_sequencer.
// Poll checks follow PIC_POLL_CMD_EN the same way the design does.
module tb_pic_command_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs_b, rd_b, wr_b, a0;
    logic [7:0] din, dout, irr, isr, poll_word;
    logic       oe;
    logic       f_icw1, f_icw2, f_icw3, f_icw4, f_ocw1, f_ocw2, f_ocw3;
    logic [7:0] icw1_reg, icw2_reg, icw3_reg, icw4_reg, imr, ocw2_reg, ocw3_reg;
    logic       init_done, poll_ack;
    logic [6:0] flags;

    always #5 clk = ~clk;

    pic_command_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .chip_select_bar     (cs_b),
        .read_bar            (rd_b),
        .write_bar           (wr_b),
        .A0                  (a0),
        .data_bus_buffer_in  (din),
        .data_bus_buffer_out (dout),
        .data_bus_oe         (oe),
        .irr_in              (irr),
        .isr_in              (isr),
        .poll_word_in        (poll_word),
        .ICW1_flag           (f_icw1),
        .ICW2_flag           (f_icw2),
        .ICW3_flag           (f_icw3),
        .ICW4_flag           (f_icw4),
        .OCW1_flag           (f_ocw1),
        .OCW2_flag           (f_ocw2),
        .OCW3_flag           (f_ocw3),
        .icw1_reg            (icw1_reg),
        .icw2_reg            (icw2_reg),
        .icw3_reg            (icw3_reg),
        .icw4_reg            (icw4_reg),
        .imr_out             (imr),
        .ocw2_reg            (ocw2_reg),
        .ocw3_reg            (ocw3_reg),
        .init_done           (init_done),
        .poll_ack            (poll_ack)
    );

    assign flags = {f_ocw3, f_ocw2, f_ocw1, f_icw4, f_icw3, f_icw2, f_icw1};

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [6:0] seen, first, second;
    logic       w_oe;
    logic [7:0] w_dout, r_data;
    logic       r_oe;
    int         r_ack;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One strobe low period, one high; flags sampled on the following negedges
    task automatic do_wr(input logic ad, input logic [7:0] d, input logic with_rd);
        seen = '0;
        @(negedge clk);
        cs_b = 1'b0; a0 = ad; din = d; wr_b = 1'b0; rd_b = ~with_rd;
        #2;
        w_oe = oe; w_dout = dout;
        @(negedge clk);
        seen |= flags; wr_b = 1'b1; rd_b = 1'b1;
        @(negedge clk);
        seen |= flags; first = flags;
        @(negedge clk);
        seen |= flags; second = flags; cs_b = 1'b1;
    endtask

    task automatic do_rd(input logic ad);
        @(negedge clk);
        cs_b = 1'b0; rd_b = 1'b0; a0 = ad;
        #2;
        r_data = dout; r_oe = oe;
        @(negedge clk);
        rd_b = 1'b1; cs_b = 1'b1;
        r_ack = 0;
        repeat (3) begin
            @(negedge clk);
            r_ack += int'(poll_ack);
        end
    endtask

    initial begin
        reset = 1'b1; cs_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; a0 = 1'b0;
        din = 8'h00; irr = 8'h3C; isr = 8'h81; poll_word = 8'h83;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_flags", flags, 7'h00);
        check("rst_imr", imr, 8'hFF);
        check("rst_init_done", init_done, 1'b0);
        check("rst_icw1", icw1_reg, 8'h00);
        check("rst_oe", oe, 1'b0);
        check("rst_dout", dout, 8'h00);

        // single, no ICW4
        do_wr(1'b0, 8'h12, 1'b0);
        check("single_icw1_seen", seen, 7'h01);
        check("single_icw1_pulse", first, 7'h01);
        check("single_icw1_end", second, 7'h00);
        check("single_imr_clr", imr, 8'h00);
        do_wr(1'b1, 8'h20, 1'b0);
        check("single_icw2_seen", seen, 7'h02);
        check("single_icw2", icw2_reg, 8'h20);
        check("single_done", init_done, 1'b1);

        // cascade with ICW4
        do_wr(1'b0, 8'h11, 1'b0);
        check("casc_icw1", seen, 7'h01);
        check("casc_not_done", init_done, 1'b0);
        do_wr(1'b1, 8'h08, 1'b0);
        check("casc_icw2", seen, 7'h02);
        do_wr(1'b1, 8'h04, 1'b0);
        check("casc_icw3", seen, 7'h04);
        check("casc_icw3_reg", icw3_reg, 8'h04);
        check("casc_mid_not_done", init_done, 1'b0);
        do_wr(1'b1, 8'h01, 1'b0);
        check("casc_icw4", seen, 7'h08);
        check("casc_icw4_reg", icw4_reg, 8'h01);
        check("casc_done", init_done, 1'b1);

        // READY decode and read-back
        do_wr(1'b1, 8'hA5, 1'b0);
        check("ocw1_flag", seen, 7'h10);
        check("ocw1_imr", imr, 8'hA5);
        do_wr(1'b0, 8'h20, 1'b0);
        check("ocw2_flag", seen, 7'h20);
        check("ocw2_reg", ocw2_reg, 8'h20);
        do_rd(1'b0);
        check("rd_irr_default", r_data, 8'h3C);
        do_wr(1'b0, 8'h0B, 1'b0);
        check("ocw3_flag", seen, 7'h40);
        do_rd(1'b0);
        check("rd_isr", r_data, 8'h81);
        check("rd_oe", r_oe, 1'b1);
        do_wr(1'b0, 8'h08, 1'b0);
        check("ocw3_rr0_kept", ocw3_reg[1:0], 2'b11);
        do_wr(1'b0, 8'h0A, 1'b0);
        do_rd(1'b0);
        check("rd_irr_sel", r_data, 8'h3C);
        do_rd(1'b1);
        check("rd_imr", r_data, 8'hA5);

        // restart from S_ICW3
        do_wr(1'b0, 8'h11, 1'b0);
        do_wr(1'b1, 8'h08, 1'b0);
        do_wr(1'b0, 8'h20, 1'b0);
        check("icw3_a0_0_ignored", seen, 7'h00);
        do_wr(1'b0, 8'h11, 1'b0);
        check("restart_icw1", seen, 7'h01);
        check("restart_imr", imr, 8'h00);
        check("restart_not_done", init_done, 1'b0);
        do_wr(1'b1, 8'h08, 1'b0);
        check("restart_in_icw2", seen, 7'h02);

        // reset with write strobe low
        @(negedge clk);
        cs_b = 1'b0; a0 = 1'b0; din = 8'h12; wr_b = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wr_b = 1'b1; seen = '0;
        repeat (3) begin
            @(negedge clk);
            seen |= flags;
        end
        cs_b = 1'b1;
        check("rst_mid_noflag", seen, 7'h00);
        check("rst_mid_imr", imr, 8'hFF);
        check("rst_mid_state", init_done, 1'b0);
        do_wr(1'b1, 8'h55, 1'b0);
        check("icw1_state_ignore", seen, 7'h00);

        // read/write clash
        do_wr(1'b0, 8'h12, 1'b0);
        do_wr(1'b1, 8'h20, 1'b1);
        check("clash_oe", w_oe, 1'b0);
        check("clash_dout", w_dout, 8'h00);
        check("clash_commit", seen, 7'h02);
        check("clash_done", init_done, 1'b1);

        // chip select released before the strobe
        @(negedge clk);
        cs_b = 1'b0; a0 = 1'b1; din = 8'hFF; wr_b = 1'b0;
        @(negedge clk);
        cs_b = 1'b1;
        @(negedge clk);
        wr_b = 1'b1; seen = '0;
        repeat (3) begin
            @(negedge clk);
            seen |= flags;
        end
        check("cs_abort_noflag", seen, 7'h00);
        check("cs_abort_imr", imr, 8'h00);

        // poll command
        do_wr(1'b0, 8'h0C, 1'b0);
        check("poll_ocw3", seen, 7'h40);
        do_rd(1'b1);
`ifdef PIC_POLL_CMD_EN
        check("poll_word", r_data, 8'h83);
        check("poll_ack", r_ack, 1);
`else
        check("nopoll_imr", r_data, 8'h00);
        check("nopoll_ack", r_ack, 0);
`endif
        do_rd(1'b0);
        check("after_poll_irr", r_data, 8'h3C);
        check("after_poll_ack", r_ack, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
